// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Packs field-level RV32I instruction requests into 32-bit instruction words
//   and writes them to consecutive instruction-memory locations. The boot/test
//   loader uses it to fill instruction memory while the core is held in reset.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   start               pulse: clear pointer/count/error, abort in-flight work
//   req_valid/req_ready request handshake
//   req_fmt             0 R, 1 I, 2 S, 3 B, 4 U, 5 J (6/7 illegal)
//   req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm
//                       instruction fields
//   imem_we/addr/wdata  one-cycle instruction-memory write port
//   count, full         words written since reset/start, memory full flag
//   err, err_code       sticky error flag and first error code
//                       (01 illegal fmt, 10 imm range, 11 imm misaligned)
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_fmt,
    input  logic [6:0]            req_opcode,
    input  logic [4:0]            req_rd,
    input  logic [4:0]            req_rs1,
    input  logic [4:0]            req_rs2,
    input  logic [2:0]            req_funct3,
    input  logic [6:0]            req_funct7,
    input  logic [31:0]           req_imm,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  err,
    output logic [1:0]            err_code
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_FMT   = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_ALIGN = 2'b11;

    localparam logic [ADDR_WIDTH:0] PTR_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Pack the registered fields into an instruction word by format.
    function automatic logic [31:0] encode_word(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (fmt)
            FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Legality check; the fmt check wins over range, range wins over alignment.
    function automatic logic [1:0] check_req(
        input logic [2:0]  fmt,
        input logic [31:0] imm
    );
        logic [1:0] code;
        code = ERR_NONE;
        case (fmt)
            FMT_R: code = ERR_NONE;
            FMT_I, FMT_S: begin
                if ((imm[31:11] != {21{1'b0}}) && (imm[31:11] != {21{1'b1}})) begin
                    code = ERR_RANGE;
                end else begin
                    code = ERR_NONE;
                end
            end
            FMT_B: begin
                if ((imm[31:12] != {20{1'b0}}) && (imm[31:12] != {20{1'b1}})) begin
                    code = ERR_RANGE;
                end else if (imm[0]) begin
                    code = ERR_ALIGN;
                end else begin
                    code = ERR_NONE;
                end
            end
            FMT_U: begin
                if (imm[11:0] != 12'h000) begin
                    code = ERR_RANGE;
                end else begin
                    code = ERR_NONE;
                end
            end
            FMT_J: begin
                if ((imm[31:20] != {12{1'b0}}) && (imm[31:20] != {12{1'b1}})) begin
                    code = ERR_RANGE;
                end else if (imm[0]) begin
                    code = ERR_ALIGN;
                end else begin
                    code = ERR_NONE;
                end
            end
            default: code = ERR_FMT;
        endcase
        return code;
    endfunction

    state_t                state_q, state_d;
    logic [2:0]            fmt_q, fmt_d;
    logic [6:0]            op_q, op_d;
    logic [4:0]            rd_q, rd_d;
    logic [4:0]            rs1_q, rs1_d;
    logic [4:0]            rs2_q, rs2_d;
    logic [2:0]            f3_q, f3_d;
    logic [6:0]            f7_q, f7_d;
    logic [31:0]           imm_q, imm_d;
    logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
    logic                  we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [1:0]            chk_s;
    logic                  full_s;
    logic                  ready_s;

    // The pointer never wraps, so its top bit alone marks a full memory.
    assign full_s  = ptr_q[ADDR_WIDTH];
    assign ready_s = (state_q == ST_IDLE) && !full_s && !start;
    assign chk_s   = check_req(fmt_q, imm_q);

    // Next-state, field capture, encode and pointer update.
    always_comb begin
        state_d    = state_q;
        fmt_d      = fmt_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        f3_d       = f3_q;
        f7_d       = f7_q;
        imm_d      = imm_q;
        ptr_d      = ptr_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_s) begin
                    fmt_d   = req_fmt;
                    op_d    = req_opcode;
                    rd_d    = req_rd;
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    f3_d    = req_funct3;
                    f7_d    = req_funct7;
                    imm_d   = req_imm;
                    state_d = ST_ENC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ENC: begin
                if (chk_s != ERR_NONE) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    // Only the first error since reset/start is kept.
                    if (!err_q) begin
                        err_code_d = chk_s;
                    end else begin
                        err_code_d = err_code_q;
                    end
                end else begin
                    wdata_d = encode_word(fmt_q, op_q, rd_q, rs1_q, rs2_q, f3_q, f7_q, imm_q);
                    we_d    = 1'b1;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                ptr_d   = ptr_q + PTR_ONE;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // start overrides everything and discards in-flight work.
        if (start) begin
            state_d    = ST_IDLE;
            ptr_d      = PTR_ZERO;
            we_d       = 1'b0;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end else begin
            state_d    = state_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fmt_q      <= 3'd0;
            op_q       <= 7'd0;
            rd_q       <= 5'd0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            f3_q       <= 3'd0;
            f7_q       <= 7'd0;
            imm_q      <= 32'h0000_0000;
            ptr_q      <= PTR_ZERO;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            fmt_q      <= fmt_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            f3_q       <= f3_d;
            f7_q       <= f7_d;
            imm_q      <= imm_d;
            ptr_q      <= ptr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // A start pulse during the write cycle suppresses the strobe immediately.
    assign imem_we    = we_q && !start;
    assign imem_addr  = ptr_q[ADDR_WIDTH-1:0];
    assign imem_wdata = wdata_q;
    assign count      = ptr_q;
    assign full       = full_s;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign req_ready  = ready_s;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_fmt = 3'd0;
    logic [6:0]    req_opcode = 7'd0;
    logic [4:0]    req_rd = 5'd0;
    logic [4:0]    req_rs1 = 5'd0;
    logic [4:0]    req_rs2 = 5'd0;
    logic [2:0]    req_funct3 = 3'd0;
    logic [6:0]    req_funct7 = 7'd0;
    logic [31:0]   req_imm = 32'd0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          err;
    logic [1:0]    err_code;

    instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_opcode(req_opcode),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ptr_m    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe.
    initial begin
        exp_t e;
        logic prev_we;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                chk("we_one_cycle", {31'd0, prev_we}, 32'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", imem_addr, imem_wdata);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", {30'd0, imem_addr}, {30'd0, e.addr});
                    chk("wr_data", imem_wdata, e.data);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end
            prev_we = imem_we;
        end
    end

    // Issue one request; push the expected write when it should be legal.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input bit wr, input logic [31:0] exp_data);
        int n;
        exp_t e;
        @(negedge clk);
        req_fmt = fmt; req_opcode = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_funct3 = f3; req_funct7 = f7; req_imm = imm;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: req_ready 0 for 50 cycles, expected 1");
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            // Scramble fields: the DUT must have registered them already.
            req_fmt = 3'($urandom); req_imm = $urandom; req_rd = 5'($urandom);
            req_rs1 = 5'($urandom); req_rs2 = 5'($urandom); req_opcode = 7'($urandom);
            if (wr) begin
                e.addr = ptr_m[AW-1:0];
                e.data = exp_data;
                e.cyc  = cyc + 1;
                sb.push_back(e);
                ptr_m++;
            end
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ptr_m = 0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", {30'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_code", {30'd0, err_code}, 32'd0);

        // addi x1,x0,5 ; add x3,x1,x2
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093);
        send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
        settle();
        chk("count_two", {29'd0, count}, 32'd2);
        pulse_start();
        #1;
        chk("start_count", {29'd0, count}, 32'd0);

        // sw x2,8(x1); beq x0,x0,-4; jal x1,8; lui x5,0x12345
        send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020A423);
        send(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFE000EE3);
        send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 32'h008000EF);
        send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7);
        settle();
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_ready", {31'd0, req_ready}, 32'd0);
        chk("wdata_hold", imem_wdata, 32'h123452B7);

        // Fifth request held while full must stay unaccepted.
        @(negedge clk);
        req_fmt = 3'd1; req_opcode = 7'b0010011; req_imm = 32'd1; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_blocked", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        pulse_start();
        #1;
        chk("restart_count", {29'd0, count}, 32'd0);
        chk("restart_ready", {31'd0, req_ready}, 32'd1);
        chk("restart_full", {31'd0, full}, 32'd0);

        // I imm out of range, then a legal J: first error code must stick.
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 1'b0, 32'd0);
        settle();
        chk("range_err", {31'd0, err}, 32'd1);
        chk("range_code", {30'd0, err_code}, 32'd2);
        chk("range_count", {29'd0, count}, 32'd0);
        send(3'd5, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 1'b1, 32'h0060006F);
        settle();
        chk("sticky_code", {30'd0, err_code}, 32'd2);
        chk("sticky_err", {31'd0, err}, 32'd1);
        pulse_start();
        #1;
        chk("clr_err", {31'd0, err}, 32'd0);
        chk("clr_count", {29'd0, count}, 32'd0);

        // B misaligned, then illegal fmt after start.
        send(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0);
        settle();
        chk("align_code", {30'd0, err_code}, 32'd3);
        chk("align_count", {29'd0, count}, 32'd0);
        pulse_start();
        send(3'd7, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
        settle();
        chk("fmt_code", {30'd0, err_code}, 32'd1);
        pulse_start();

        // start during WR discards the write.
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093);
        send(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b1;
        #1;
        chk("start_wr_we", {31'd0, imem_we}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        ptr_m = 0;
        chk("start_wr_count", {29'd0, count}, 32'd0);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093);

        // rst during WR discards the write.
        send(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_wr_we", {31'd0, imem_we}, 32'd0);
        chk("rst_wr_count", {29'd0, count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
        settle();
        chk("final_count", {29'd0, count}, 32'd1);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
